// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle sequencer for the single-issue LoongArch core: it walks each instruction
// through IF/ID/EXE/MEM/WB, issues the datapath strobes and keeps the trace counters.
module mc_ctrl_fsm #(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_rdy,
  input  logic             data_rdy,
  input  logic             id_br_only,
  input  logic             id_load,
  input  logic             id_store,
  input  logic             id_gr_we,
  output logic             inst_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic             ex_we,
  output logic             data_req,
  output logic             data_wr,
  output logic             mdr_we,
  output logic             rf_we,
  output logic             retire,
  output logic [2:0]       state,
  output logic             bus_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam int WCNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

  typedef enum logic [2:0] {
    S_IF       = 3'd0,
    S_IF_WAIT  = 3'd1,
    S_ID       = 3'd2,
    S_EXE      = 3'd3,
    S_MEM      = 3'd4,
    S_MEM_WAIT = 3'd5,
    S_WB       = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wait_q, wait_d;
  logic                load_q, load_d;
  logic                store_q, store_d;
  logic                gr_we_q, gr_we_d;
  logic                bus_err_q;
  logic                err_set;
  logic [CNT_W-1:0]    cycle_q, instret_q;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    load_d   = load_q;
    store_d  = store_q;
    gr_we_d  = gr_we_q;
    err_set  = 1'b0;
    inst_req = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    ex_we    = 1'b0;
    data_req = 1'b0;
    data_wr  = 1'b0;
    mdr_we   = 1'b0;
    rf_we    = 1'b0;
    retire   = 1'b0;

    case (state_q)
      S_IF: begin
        inst_req = 1'b1;
        wait_d   = '0;
        state_d  = S_IF_WAIT;
      end
      S_IF_WAIT: begin
        if (inst_rdy) begin
          ir_we   = 1'b1;
          state_d = S_ID;
        end else if (wait_q == WAIT_LAST) begin
          // Abort without pc_we so the same PC is refetched.
          err_set = 1'b1;
          state_d = S_IF;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_ID: begin
        load_d  = id_load;
        store_d = id_store & ~id_load;
        gr_we_d = id_gr_we;
        if (id_br_only) begin
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        ex_we   = 1'b1;
        state_d = (load_q || store_q) ? S_MEM : S_WB;
      end
      S_MEM: begin
        data_req = 1'b1;
        data_wr  = store_q;
        wait_d   = '0;
        state_d  = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (data_rdy) begin
          if (load_q) begin
            mdr_we  = 1'b1;
            state_d = S_WB;
          end else begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_IF;
          end
        end else if (wait_q == WAIT_LAST) begin
          err_set = 1'b1;
          state_d = S_IF;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        rf_we   = gr_we_q;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase

    // Reset arriving mid-instruction must not commit anything in that cycle.
    if (reset) begin
      inst_req = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      ex_we    = 1'b0;
      data_req = 1'b0;
      data_wr  = 1'b0;
      mdr_we   = 1'b0;
      rf_we    = 1'b0;
      retire   = 1'b0;
      err_set  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values seen before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IF;
      wait_q    <= '0;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      gr_we_q   <= 1'b0;
      bus_err_q <= 1'b0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      load_q    <= load_d;
      store_q   <= store_d;
      gr_we_q   <= gr_we_d;
      bus_err_q <= bus_err_q | err_set;
      cycle_q   <= cycle_q + 1'b1;
      instret_q <= instret_q + CNT_W'(retire);
    end
  end

  assign state       = state_q;
  assign bus_err     = bus_err_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: builds the expected per-cycle trace of each
// instruction from its class and wait counts, then drives and compares cycle by cycle.
module tb_mc_ctrl_fsm;

  localparam int CNT_W    = 32;
  localparam int WAIT_MAX = 4;

  // strobe vector order: inst_req ir_we pc_we ex_we data_req data_wr mdr_we rf_we retire
  localparam logic [8:0] B_IREQ = 9'b1_0000_0000;
  localparam logic [8:0] B_IRWE = 9'b0_1000_0000;
  localparam logic [8:0] B_PC   = 9'b0_0100_0000;
  localparam logic [8:0] B_EX   = 9'b0_0010_0000;
  localparam logic [8:0] B_DREQ = 9'b0_0001_0000;
  localparam logic [8:0] B_DWR  = 9'b0_0000_1000;
  localparam logic [8:0] B_MDR  = 9'b0_0000_0100;
  localparam logic [8:0] B_RF   = 9'b0_0000_0010;
  localparam logic [8:0] B_RET  = 9'b0_0000_0001;

  localparam int K_BR = 0, K_ALU = 1, K_LD = 2, K_ST = 3, K_LDST = 4;

  typedef struct packed {
    logic [2:0] st;
    logic [8:0] strb;
    logic       inst_rdy;
    logic       data_rdy;
    logic       br;
    logic       ld;
    logic       sto;
    logic       gwe;
    logic       err;
  } cyc_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             inst_rdy, data_rdy, id_br_only, id_load, id_store, id_gr_we;
  logic             inst_req, ir_we, pc_we, ex_we, data_req, data_wr, mdr_we, rf_we, retire;
  logic [2:0]       state;
  logic             bus_err;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned exp_cycles = 0;
  int unsigned exp_ret    = 0;
  logic        exp_err    = 1'b0;
  cyc_t        q[$];

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset),
    .inst_rdy(inst_rdy), .data_rdy(data_rdy),
    .id_br_only(id_br_only), .id_load(id_load), .id_store(id_store), .id_gr_we(id_gr_we),
    .inst_req(inst_req), .ir_we(ir_we), .pc_we(pc_we), .ex_we(ex_we),
    .data_req(data_req), .data_wr(data_wr), .mdr_we(mdr_we), .rf_we(rf_we),
    .retire(retire), .state(state), .bus_err(bus_err),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  wire [8:0] strb_o = {inst_req, ir_we, pc_we, ex_we, data_req, data_wr, mdr_we, rf_we, retire};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // One cycle of the trace with random noise on every input the FSM must ignore.
  function automatic cyc_t mk(input logic [2:0] st, input logic [8:0] strb);
    cyc_t c;
    c.st       = st;
    c.strb     = strb;
    c.inst_rdy = 1'($urandom_range(0, 1));
    c.data_rdy = 1'($urandom_range(0, 1));
    c.br       = 1'($urandom_range(0, 1));
    c.ld       = 1'($urandom_range(0, 1));
    c.sto      = 1'($urandom_range(0, 1));
    c.gwe      = 1'($urandom_range(0, 1));
    c.err      = 1'b0;
    return c;
  endfunction

  // iw/mw: wait cycles before rdy; a value >= WAIT_MAX means rdy never comes.
  task automatic push_instr(input int kind, input logic gwe, input int iw, input int mw);
    cyc_t c;
    logic is_ld, is_st;
    is_ld = (kind == K_LD) || (kind == K_LDST);
    is_st = (kind == K_ST);
    q.push_back(mk(3'd0, B_IREQ));
    for (int i = 0; i < iw && i < WAIT_MAX; i++) begin
      c = mk(3'd1, '0);
      c.inst_rdy = 1'b0;
      c.err = (i == WAIT_MAX - 1);
      q.push_back(c);
    end
    if (iw >= WAIT_MAX) return;
    c = mk(3'd1, B_IRWE);
    c.inst_rdy = 1'b1;
    q.push_back(c);
    c = mk(3'd2, (kind == K_BR) ? (B_PC | B_RET) : 9'd0);
    c.br  = (kind == K_BR);
    c.gwe = gwe;
    if (kind != K_BR) begin
      c.ld  = is_ld;
      c.sto = is_st || (kind == K_LDST);
    end
    q.push_back(c);
    if (kind == K_BR) return;
    q.push_back(mk(3'd3, B_EX));
    if (is_ld || is_st) begin
      q.push_back(mk(3'd4, B_DREQ | (is_st ? B_DWR : 9'd0)));
      for (int i = 0; i < mw && i < WAIT_MAX; i++) begin
        c = mk(3'd5, '0);
        c.data_rdy = 1'b0;
        c.err = (i == WAIT_MAX - 1);
        q.push_back(c);
      end
      if (mw >= WAIT_MAX) return;
      c = mk(3'd5, is_ld ? B_MDR : (B_PC | B_RET));
      c.data_rdy = 1'b1;
      q.push_back(c);
      if (is_st) return;
    end
    q.push_back(mk(3'd6, B_PC | B_RET | (gwe ? B_RF : 9'd0)));
  endtask

  task automatic run_cycle(input cyc_t c);
    @(negedge clk);
    reset      = 1'b0;
    inst_rdy   = c.inst_rdy;
    data_rdy   = c.data_rdy;
    id_br_only = c.br;
    id_load    = c.ld;
    id_store   = c.sto;
    id_gr_we   = c.gwe;
    #1;
    check("state", 32'(state), 32'(c.st));
    check("strobes", 32'(strb_o), 32'(c.strb));
    check("bus_err", 32'(bus_err), 32'(exp_err));
    check("cycle_cnt", cycle_cnt, exp_cycles);
    check("instret_cnt", instret_cnt, exp_ret);
    @(posedge clk);
    exp_cycles++;
    if (c.strb[0]) exp_ret++;
    if (c.err) exp_err = 1'b1;
  endtask

  task automatic drain();
    while (q.size() > 0) run_cycle(q.pop_front());
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_strobes"}, 32'(strb_o), 32'd0);
    check({tag, "_bus_err"}, 32'(bus_err), 32'd0);
    check({tag, "_cycle"}, cycle_cnt, 32'd0);
    check({tag, "_instret"}, instret_cnt, 32'd0);
  endtask

  initial begin
    cyc_t c;
    int   kind, r;
    reset = 1'b1;
    inst_rdy = 1'b1; data_rdy = 1'b1;
    id_br_only = 1'b0; id_load = 1'b0; id_store = 1'b0; id_gr_we = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_state("por");

    // Directed cases: ALU, beq with gr_we, load with 3 waits, store, fetch timeout, ALU after.
    push_instr(K_ALU, 1'b1, 0, 0);
    push_instr(K_BR, 1'b1, 0, 0);
    push_instr(K_LD, 1'b1, 0, 3);
    push_instr(K_ST, 1'b1, 0, 0);
    push_instr(K_ALU, 1'b1, WAIT_MAX, 0);
    push_instr(K_ALU, 1'b0, WAIT_MAX - 1, 0);
    push_instr(K_LDST, 1'b1, 1, WAIT_MAX - 1);
    drain();
    check("err_sticky", 32'(bus_err), 32'd1);

    // Reset landing in MEM_WAIT with data_rdy high.
    push_instr(K_LD, 1'b1, 0, 2);
    while (q.size() > 0 && q[0].st != 3'd5) run_cycle(q.pop_front());
    q.delete();
    @(negedge clk);
    reset = 1'b1; data_rdy = 1'b1; inst_rdy = 1'b1;
    #1;
    check("rst_pre_state", 32'(state), 32'd5);
    check("rst_pre_strobes", 32'(strb_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_state("midrst");
    exp_cycles = 0; exp_ret = 0; exp_err = 1'b0;

    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 4));
      r = int'($urandom_range(0, 15));
      push_instr(kind, 1'($urandom_range(0, 1)),
                 (r == 15) ? WAIT_MAX : (r % WAIT_MAX),
                 (r == 14) ? WAIT_MAX : int'($urandom_range(0, WAIT_MAX - 1)));
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
